dot_product_engine: RTL and testbench

- Compute-side responder to the controller's start/done handshake.
- On a start pulse, reads vector A (addresses 0..N_ELEM-1) and vector B (addresses B_BASE..B_BASE+N_ELEM-1) from the shared operand memory.
- Accumulates the element-wise products, returns an 8-bit result and a one-cycle done pulse.
- Owns the memory read port while mode_compute is high.

---
 rtl/dot_product_engine_if.sv | 41 ++++
 rtl/dot_product_engine.sv | 119 +++++++++++
 tb/tb_dot_product_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_engine_if.sv
// Handshake and memory-read bundle between the controller and the dot-product engine.
//   mode_compute     : controller grants the operand memory read port to the engine
//   comp_start       : one-cycle start pulse from the controller
//   comp_done        : one-cycle completion pulse from the engine
//   comp_result      : dot-product result, held between completions
//   comp_busy        : engine is running an operation
//   comp_mem_addr    : engine's memory read address
//   comp_mem_rd_data : memory read data, valid one cycle after the address
// Modports: master = controller/memory side, slave = engine side.
interface dot_product_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();
  logic              mode_compute;
  logic              comp_start;
  logic              comp_done;
  logic [DATA_W-1:0] comp_result;
  logic              comp_busy;
  logic [ADDR_W-1:0] comp_mem_addr;
  logic [DATA_W-1:0] comp_mem_rd_data;

  modport master (
    output mode_compute,
    output comp_start,
    output comp_mem_rd_data,
    input  comp_done,
    input  comp_result,
    input  comp_busy,
    input  comp_mem_addr
  );

  modport slave (
    input  mode_compute,
    input  comp_start,
    input  comp_mem_rd_data,
    output comp_done,
    output comp_result,
    output comp_busy,
    output comp_mem_addr
  );
endinterface

// File: rtl/dot_product_engine.sv
// Dot-product engine: on a start pulse reads vector A (addresses 0..N_ELEM-1) and vector B
// (addresses B_BASE..B_BASE+N_ELEM-1) from the shared operand memory, accumulates the
// element-wise products and returns a DATA_W-bit result with a one-cycle done pulse.
// Three cycles per element (address A/B, capture A, multiply-accumulate).
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : dot_product_engine_if.slave (start/done handshake, result, busy, memory read port)
// Build option: define DOT_PRODUCT_SATURATE_EN to clamp the result to all-ones when the
// sum does not fit in DATA_W bits; otherwise the result is the truncated low DATA_W bits.
module dot_product_engine #(
  parameter int unsigned N_ELEM = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned B_BASE = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N_ELEM)
) (
  input logic                 clk,
  input logic                 rst,
  dot_product_engine_if.slave bus
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] B_ADDR   = ADDR_W'(B_BASE);

  typedef enum logic [1:0] {StIdle, StAddrA, StAddrB, StMac} state_e;

  state_e              state;
  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   a_reg;
  logic                done_q;
  logic                busy_q;
  logic [DATA_W-1:0]   result_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_next;
  logic [DATA_W-1:0]   result_next;

  // In StMac the read data is B[idx]; a_reg holds A[idx].
  always_comb begin
    prod     = a_reg * bus.comp_mem_rd_data;
    acc_next = acc + ACC_W'(prod);
`ifdef DOT_PRODUCT_SATURATE_EN
    if (|acc_next[ACC_W-1:DATA_W]) begin
      result_next = '1;
    end else begin
      result_next = acc_next[DATA_W-1:0];
    end
`else
    result_next = acc_next[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      idx      <= '0;
      acc      <= '0;
      a_reg    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state != StIdle && !bus.mode_compute) begin
        // Read port taken away mid-operation: abandon without a result.
        state  <= StIdle;
        busy_q <= 1'b0;
        acc    <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (bus.comp_start && bus.mode_compute) begin
              acc    <= '0;
              idx    <= '0;
              addr_q <= '0;
              busy_q <= 1'b1;
              state  <= StAddrA;
            end
          end
          StAddrA: begin
            addr_q <= B_ADDR + ADDR_W'(idx);
            state  <= StAddrB;
          end
          StAddrB: begin
            a_reg <= bus.comp_mem_rd_data;
            state <= StMac;
          end
          StMac: begin
            if (idx == LAST_IDX) begin
              result_q <= result_next;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= StIdle;
            end else begin
              acc    <= acc_next;
              idx    <= idx + IDX_ONE;
              addr_q <= ADDR_W'(idx) + ADDR_ONE;
              state  <= StAddrA;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign bus.comp_done     = done_q;
  assign bus.comp_busy     = busy_q;
  assign bus.comp_result   = result_q;
  assign bus.comp_mem_addr = addr_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine: expected results are queued when a run is
// started and compared when comp_done fires.
module tb_dot_product_engine;

  localparam int unsigned N_ELEM = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned B_BASE = 8;

  typedef logic [7:0] vec_t [N_ELEM];

  logic clk;
  logic rst;

  dot_product_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dot_product_engine #(
    .N_ELEM(N_ELEM),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .B_BASE(B_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memory with one-cycle read latency.
  logic [7:0] mem [16];
  always @(posedge clk) bus.comp_mem_rd_data <= mem[bus.comp_mem_addr];

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] last_res = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input vec_t a, input vec_t b);
    int s;
    s = 0;
    for (int i = 0; i < int'(N_ELEM); i++) s += int'(a[i]) * int'(b[i]);
`ifdef DOT_PRODUCT_SATURATE_EN
    if (s > 255) return 8'hFF;
`endif
    return 8'(s);
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.comp_done === 1'b1) begin
      logic [7:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", {31'b0, bus.comp_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result", {24'b0, bus.comp_result}, {24'b0, e});
      end
    end
  end

  task automatic load(input vec_t a, input vec_t b);
    for (int i = 0; i < int'(N_ELEM); i++) begin
      mem[i]          = a[i];
      mem[B_BASE + i] = b[i];
    end
  endtask

  // Full run. b2b: called at the negedge where the previous done was seen.
  task automatic run_op(input vec_t a, input vec_t b, input bit b2b, input bit chk_addr,
                        input bit extra, input string tag);
    int cnt0;
    int done_cyc;
    bit seen;
    logic [7:0] e;
    if (!b2b) begin
      @(negedge clk);
      check_eq({tag, "_pre_done"}, {31'b0, bus.comp_done}, 32'd0);
    end
    load(a, b);
    e = model(a, b);
    exp_q.push_back(e);
    cnt0 = done_cnt;
    bus.mode_compute = 1'b1;
    bus.comp_start   = 1'b1;
    @(negedge clk);
    bus.comp_start = 1'b0;
    check_eq({tag, "_busy_rise"}, {31'b0, bus.comp_busy}, 32'd1);
    if (chk_addr) check_eq({tag, "_addr0"}, {28'b0, bus.comp_mem_addr}, 32'd0);
    seen = 1'b0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      bus.comp_start = extra && (cyc == 5 || cyc == 12);
      if (chk_addr && cyc < 24) begin
        if (cyc % 3 == 0)
          check_eq({tag, "_addr_a"}, {28'b0, bus.comp_mem_addr}, 32'(cyc / 3));
        if (cyc % 3 == 1)
          check_eq({tag, "_addr_b"}, {28'b0, bus.comp_mem_addr}, 32'(B_BASE + cyc / 3));
      end
      if (bus.comp_done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
        check_eq({tag, "_busy_fall"}, {31'b0, bus.comp_busy}, 32'd0);
      end
    end
    bus.comp_start = 1'b0;
    check_eq({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check_eq({tag, "_latency"}, 32'(done_cyc), 32'd24);
    #1;
    check_eq({tag, "_done_cnt"}, 32'(done_cnt - cnt0), 32'd1);
    last_res = e;
  endtask

  task automatic start_only(input vec_t a, input vec_t b);
    @(negedge clk);
    load(a, b);
    bus.mode_compute = 1'b1;
    bus.comp_start   = 1'b1;
    @(negedge clk);
    bus.comp_start = 1'b0;
  endtask

  vec_t va, vb;
  int cnt0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mode_compute = 1'b0;
    bus.comp_start   = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_done",   {31'b0, bus.comp_done}, 32'd0);
    check_eq("rst_busy",   {31'b0, bus.comp_busy}, 32'd0);
    check_eq("rst_result", {24'b0, bus.comp_result}, 32'd0);
    check_eq("rst_addr",   {28'b0, bus.comp_mem_addr}, 32'd0);
    rst = 1'b0;

    // A=1..8, B=1 -> 36, with address sequence check.
    for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd1; end
    run_op(va, vb, 1'b0, 1'b1, 1'b0, "seq");

    // Abort: drop mode_compute at cycle 10 of a run.
    for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; end
    start_only(va, vb);
    cnt0 = done_cnt;
    for (int cyc = 1; cyc <= 9; cyc++) @(negedge clk);
    bus.mode_compute = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'b0, bus.comp_busy}, 32'd0);
    repeat (30) @(negedge clk);
    #1;
    check_eq("abort_no_done", 32'(done_cnt - cnt0), 32'd0);
    check_eq("abort_result", {24'b0, bus.comp_result}, {24'b0, last_res});
    bus.mode_compute = 1'b1;

    // Recovery run: 16*16*8 = 2048 (wraps to 0, or clamps when saturating).
    for (int i = 0; i < 8; i++) begin va[i] = 8'd16; vb[i] = 8'd16; end
    run_op(va, vb, 1'b0, 1'b0, 1'b0, "big");

    // 3*5 + 2*7 = 29, then back-to-back A=0 -> 0.
    va = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    vb = '{8'd5, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd7};
    run_op(va, vb, 1'b0, 1'b0, 1'b0, "mix");
    for (int i = 0; i < 8; i++) va[i] = 8'd0;
    run_op(va, vb, 1'b1, 1'b0, 1'b0, "b2b_zero");

    // Extra start pulses at cycles 5 and 12 are ignored. A=1..8, B=3 -> 108.
    for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd3; end
    run_op(va, vb, 1'b0, 1'b0, 1'b1, "extra");

    // Start with mode_compute low is ignored.
    @(negedge clk);
    cnt0 = done_cnt;
    bus.mode_compute = 1'b0;
    bus.comp_start   = 1'b1;
    @(negedge clk);
    bus.comp_start = 1'b0;
    check_eq("nomode_busy", {31'b0, bus.comp_busy}, 32'd0);
    repeat (30) @(negedge clk);
    #1;
    check_eq("nomode_no_done", 32'(done_cnt - cnt0), 32'd0);

    // Reset at cycle 15 of a run.
    for (int i = 0; i < 8; i++) begin va[i] = 8'd200; vb[i] = 8'd5; end
    start_only(va, vb);
    cnt0 = done_cnt;
    for (int cyc = 1; cyc <= 14; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_done",   {31'b0, bus.comp_done}, 32'd0);
    check_eq("mrst_busy",   {31'b0, bus.comp_busy}, 32'd0);
    check_eq("mrst_result", {24'b0, bus.comp_result}, 32'd0);
    check_eq("mrst_addr",   {28'b0, bus.comp_mem_addr}, 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check_eq("mrst_no_done", 32'(done_cnt - cnt0), 32'd0);

    for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd1; end
    run_op(va, vb, 1'b0, 1'b0, 1'b0, "post_rst");

    repeat (3) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
